// File: rtl/separar8_pkg.sv
// Shared types and constants for the separar8 score-byte unpacker.
package separar8_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_t;

  localparam logic [1:0] DIG_NONE  = 2'b00;
  localparam logic [1:0] DIG_LO    = 2'b01;
  localparam logic [1:0] DIG_HI    = 2'b10;
  localparam logic [3:0] BLANK_NIB = 4'hF;

  function automatic logic nib_not_bcd(input logic [3:0] n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/separar8_div.sv
// Digit hold counter: counts cycles within one digit slot, flags the last one.
module separar8_div #(
  parameter int REFRESH_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int CW = $clog2(REFRESH_DIV + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else                count <= count + CW'(1);
  end

  assign tc = (count == CW'(REFRESH_DIV - 1));

endmodule

// File: rtl/separar8.sv
// Packed score byte -> time-multiplexed units/tens digit bus with one-hot select.
// Optional SEPARAR8_BCD_CHECK_EN: flags and blanks non-decimal nibbles.
module separar8
  import separar8_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] nib_out,
  output logic [1:0] dig_sel,
  output logic       out_valid,
  output logic       bcd_err,
  output logic [1:0] dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE and on the last cycle of SHOW_HI, so a
  // frame always shows both digits of the same byte.

  state_t     state, state_n;
  logic [7:0] latched, latched_n;
  logic       tc, clear, xfer;

  function automatic logic [3:0] disp(input logic [3:0] n);
`ifdef SEPARAR8_BCD_CHECK_EN
    return nib_not_bcd(n) ? BLANK_NIB : n;
`else
    return n;
`endif
  endfunction

  separar8_div #(.REFRESH_DIV(REFRESH_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tc    (tc)
  );

  assign in_ready  = (state == IDLE) || (state == SHOW_HI && tc);
  assign xfer      = in_valid && in_ready;
  assign clear     = (state_n != state);
  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    latched_n = latched;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n   = SHOW_LO;
          latched_n = byte_in;
        end
      end
      SHOW_LO: begin
        if (tc) state_n = SHOW_HI;
      end
      SHOW_HI: begin
        if (tc) begin
          state_n = SHOW_LO;
          if (xfer) latched_n = byte_in;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      latched   <= 8'h00;
      nib_out   <= 4'h0;
      dig_sel   <= DIG_NONE;
      out_valid <= 1'b0;
    end else begin
      state   <= state_n;
      latched <= latched_n;
      case (state_n)
        SHOW_LO: begin
          nib_out   <= disp(latched_n[3:0]);
          dig_sel   <= DIG_LO;
          out_valid <= 1'b1;
        end
        SHOW_HI: begin
          nib_out   <= disp(latched_n[7:4]);
          dig_sel   <= DIG_HI;
          out_valid <= 1'b1;
        end
        default: begin
          nib_out   <= 4'h0;
          dig_sel   <= DIG_NONE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEPARAR8_BCD_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset)     bcd_err <= 1'b0;
    else if (xfer) bcd_err <= nib_not_bcd(byte_in[7:4]) | nib_not_bcd(byte_in[3:0]);
  end
`else
  assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_separar8.sv
// Bench for separar8: two instances (REFRESH_DIV=4 and 1) against a frame-position
// reference model, plus directed sequences for latency, back-pressure, BCD and reset.
module tb_separar8;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] byte_in   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [3:0] nib_out   [2];
  logic [1:0] dig_sel   [2];
  logic       out_valid [2];
  logic       bcd_err   [2];
  logic [1:0] dbg_state [2];

  always #5 clock = ~clock;

  separar8 #(.REFRESH_DIV(D0)) u0 (
    .clock(clock), .reset(reset), .byte_in(byte_in[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .nib_out(nib_out[0]), .dig_sel(dig_sel[0]),
    .out_valid(out_valid[0]), .bcd_err(bcd_err[0]), .dbg_state(dbg_state[0])
  );

  separar8 #(.REFRESH_DIV(D1)) u1 (
    .clock(clock), .reset(reset), .byte_in(byte_in[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .nib_out(nib_out[1]), .dig_sel(dig_sel[1]),
    .out_valid(out_valid[1]), .bcd_err(bcd_err[1]), .dbg_state(dbg_state[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which byte is shown and where we are inside its frame.
  int         m_div  [2];
  bit         m_act  [2];
  int         m_t    [2];
  logic [7:0] m_byte [2];
  logic       m_err  [2];
  bit         acc    [2];

  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bad_byte(input logic [7:0] b);
`ifdef SEPARAR8_BCD_CHECK_EN
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] shown(input logic [3:0] n);
`ifdef SEPARAR8_BCD_CHECK_EN
    return (n > 4'd9) ? 4'hF : n;
`else
    return n;
`endif
  endfunction

  function automatic logic m_ready(input int i);
    return !m_act[i] || (m_t[i] == 2 * m_div[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_byte[i] = 8'h00; m_err[i] = 1'b0; acc[i] = 1'b0;
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] e_nib;
      logic [1:0] e_sel;
      if (!m_act[i])               begin e_nib = 4'h0; e_sel = 2'b00; end
      else if (m_t[i] < m_div[i])  begin e_nib = shown(m_byte[i][3:0]); e_sel = 2'b01; end
      else                         begin e_nib = shown(m_byte[i][7:4]); e_sel = 2'b10; end
      chk($sformatf("u%0d_nib", i), 8'(nib_out[i]), 8'(e_nib));
      chk($sformatf("u%0d_sel", i), 8'(dig_sel[i]), 8'(e_sel));
      chk($sformatf("u%0d_ovalid", i), 8'(out_valid[i]), 8'(m_act[i]));
      chk($sformatf("u%0d_bcderr", i), 8'(bcd_err[i]), 8'(m_err[i]));
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic cycle();
    logic rdy [2];
    for (int i = 0; i < 2; i++) begin
      rdy[i] = m_ready(i);
      chk($sformatf("u%0d_ready", i), 8'(in_ready[i]), 8'(rdy[i]));
    end
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      if (reset) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_byte[i] = 8'h00; m_err[i] = 1'b0;
      end else if (in_valid[i] && rdy[i]) begin
        m_act[i] = 1'b1; m_t[i] = 0; m_byte[i] = byte_in[i]; m_err[i] = bad_byte(byte_in[i]);
        acc[i] = 1'b1;
      end else if (m_act[i]) begin
        m_t[i] = (m_t[i] + 1) % (2 * m_div[i]);
      end
    end
    #1;
    check_outs();
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int n = 0;
    in_valid[i] = 1'b1;
    byte_in[i]  = b;
    do begin
      cycle();
      n++;
    end while (!acc[i] && n < 2 * m_div[i] + 2);
    if (!acc[i]) chk($sformatf("u%0d_accept_timeout", i), 8'd0, 8'd1);
    in_valid[i] = 1'b0;
  endtask

  initial begin
    int waited;
    m_div[0] = D0;
    m_div[1] = D1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      byte_in[i]  = 8'h00;
    end

    // Reset values after two reset cycles.
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    chk("rst_ready", 8'(in_ready[0]), 8'd1);
    check_outs();
    reset = 1'b0;

    // 0x57 latency and frame repeat.
    send(0, 8'h57);
    for (int k = 0; k < 9; k++) exp_q.push_back((k < 4 || k == 8) ? 4'd7 : 4'd5);
    for (int k = 0; k < 9; k++) begin
      chk("seq57_nib", 8'(nib_out[0]), 8'(exp_q.pop_front()));
      chk("seq57_sel", 8'(dig_sel[0]), (k < 4 || k == 8) ? 8'd1 : 8'd2);
      if (k < 8) cycle();
    end

    // Back-pressure: 0x83 offered on the first units cycle of a frame.
    in_valid[0] = 1'b1;
    byte_in[0]  = 8'h83;
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!acc[0] && waited < 20);
    in_valid[0] = 1'b0;
    chk("bp_wait", 8'(waited), 8'd8);
    for (int k = 0; k < 8; k++) begin
      chk("seq83_nib", 8'(nib_out[0]), (k < 4) ? 8'd3 : 8'd8);
      cycle();
    end

    // REFRESH_DIV=1 alternation.
    send(1, 8'h12);
    for (int k = 0; k < 4; k++) begin
      chk("div1_nib", 8'(nib_out[1]), (k % 2 == 0) ? 8'd2 : 8'd1);
      chk("div1_ready", 8'(in_ready[1]), (k % 2 == 0) ? 8'd0 : 8'd1);
      cycle();
    end

    // Non-decimal nibble handling.
    send(0, 8'h3A);
`ifdef SEPARAR8_BCD_CHECK_EN
    chk("bcd_units", 8'(nib_out[0]), 8'h0F);
    chk("bcd_err_set", 8'(bcd_err[0]), 8'd1);
`else
    chk("bcd_units", 8'(nib_out[0]), 8'h0A);
    chk("bcd_err_set", 8'(bcd_err[0]), 8'd0);
`endif
    chk("bcd_units_sel", 8'(dig_sel[0]), 8'd1);
    repeat (D0) cycle();
    chk("bcd_tens", 8'(nib_out[0]), 8'd3);
    send(0, 8'h45);
    chk("bcd_err_clr", 8'(bcd_err[0]), 8'd0);

    // Mid-frame reset while showing tens of 0x99.
    send(0, 8'h99);
    repeat (D0) cycle();
    chk("pre_rst_sel", 8'(dig_sel[0]), 8'd2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_nib", 8'(nib_out[0]), 8'd0);
    chk("rst_mid_sel", 8'(dig_sel[0]), 8'd0);
    chk("rst_mid_ready", 8'(in_ready[0]), 8'd1);
    send(0, 8'h01);
    chk("post_rst_nib", 8'(nib_out[0]), 8'd1);
    chk("post_rst_sel", 8'(dig_sel[0]), 8'd1);

    // Randomized traffic with occasional resets on both instances.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!in_valid[i] && $urandom_range(0, 3) == 0) begin
          in_valid[i] = 1'b1;
          byte_in[i]  = 8'($urandom_range(0, 255));
        end
      end
      reset = ($urandom_range(0, 149) == 0);
      cycle();
      for (int i = 0; i < 2; i++) if (acc[i]) in_valid[i] = 1'b0;
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
